// File: rtl/cfg_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
package cfg_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      SHIFT = 3'd2,
      SET   = 3'd3,
      DONE  = 3'd4
   } cfg_state_t;

   function automatic int words_per_load(input int chain_len, input int num_chains,
                                         input int word_w);
      return (chain_len * num_chains + word_w - 1) / word_w;
   endfunction

   function automatic int sub_cnt_w(input int word_w, input int num_chains);
      return (word_w / num_chains > 1) ? $clog2(word_w / num_chains) : 1;
   endfunction

   function automatic int bit_cnt_w(input int chain_len);
      return $clog2(chain_len + 1);
   endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Holds one config word and presents it NUM_CHAINS bits at a time, low slice first.
module cfg_word_serializer
   import cfg_pkg::*;
#(
   parameter int NUM_CHAINS = 4,
   parameter int WORD_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cen,
   input  logic                  load,
   input  logic                  shift,
   input  logic [WORD_W-1:0]     in_data,
   output logic [NUM_CHAINS-1:0] slice,
   output logic                  word_empty
);

   localparam int SLICES = WORD_W / NUM_CHAINS;
   localparam int SCW    = sub_cnt_w(WORD_W, NUM_CHAINS);
   localparam logic [SCW-1:0] LAST_SUB = SCW'(SLICES - 1);

   logic [WORD_W-1:0] word_q;
   logic [SCW-1:0]    sub_cnt;

   // sub_cnt parks on the last slice so it never wraps before the next load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_q  <= '0;
         sub_cnt <= '0;
      end else if (cen) begin
         if (load) begin
            word_q  <= in_data;
            sub_cnt <= '0;
         end else if (shift) begin
            word_q <= word_q >> NUM_CHAINS;
            if (!word_empty) sub_cnt <= sub_cnt + 1'b1;
         end
      end
   end

   assign slice      = word_q[NUM_CHAINS-1:0];
   // high while the slice on show is the word's last one
   assign word_empty = (sub_cnt == LAST_SUB);

endmodule

// File: rtl/cfg_chain_loader.sv
// Streams config words into NUM_CHAINS parallel shift chains, then pulses set.
module cfg_chain_loader
   import cfg_pkg::*;
#(
   parameter int NUM_CHAINS = 4,
   parameter int CHAIN_LEN  = 64,
   parameter int WORD_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cen,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WORD_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [NUM_CHAINS-1:0] shift_out,
   output logic                  shift_en,
   output logic                  set_out,
   output logic                  busy,
   output logic                  done
);

   localparam int BCW = bit_cnt_w(CHAIN_LEN);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(CHAIN_LEN - 1);

   generate
      if (WORD_W % NUM_CHAINS != 0 || CHAIN_LEN < 1) begin : g_bad_cfg
         $error("cfg_chain_loader: WORD_W must be a multiple of NUM_CHAINS and CHAIN_LEN >= 1");
      end
   endgenerate

   cfg_state_t            state, state_nx;
   logic [BCW-1:0]        bit_cnt;
   logic [NUM_CHAINS-1:0] slice;
   logic                  word_empty;
   logic                  in_load, load_word, do_shift, idle_like;

   assign in_load   = (state == FILL) || (state == SHIFT) || (state == SET);
   assign idle_like = (state == IDLE) || (state == DONE);
   assign load_word = cen && !abort && (state == FILL) && in_valid;
   assign do_shift  = cen && !abort && (state == SHIFT);

   cfg_word_serializer #(
      .NUM_CHAINS (NUM_CHAINS),
      .WORD_W     (WORD_W)
   ) u_ser (
      .clk        (clk),
      .rst        (rst),
      .cen        (cen),
      .load       (load_word),
      .shift      (do_shift),
      .in_data    (in_data),
      .slice      (slice),
      .word_empty (word_empty)
   );

   // abort wins over every other transition while a load is in flight
   always_comb begin
      state_nx = state;
      if (cen) begin
         if (abort && in_load) begin
            state_nx = IDLE;
         end else begin
            case (state)
               IDLE, DONE: if (start) state_nx = FILL;
               FILL:       if (in_valid) state_nx = SHIFT;
               SHIFT: begin
                  if (bit_cnt == LAST_BIT) state_nx = SET;
                  else if (word_empty)     state_nx = FILL;
               end
               SET:        state_nx = DONE;
               default:    state_nx = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
      end else if (cen) begin
         state <= state_nx;
         if (idle_like && start) bit_cnt <= '0;
         else if (do_shift)      bit_cnt <= bit_cnt + 1'b1;
      end
   end

   assign in_ready  = cen && (state == FILL);
   assign shift_en  = cen && (state == SHIFT);
   assign set_out   = cen && !abort && (state == SET);
   assign shift_out = (state == SHIFT) ? slice : '0;
   assign busy      = in_load;
   assign done      = (state == DONE);

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench: loads queue expected chain slices, negedge monitors pop and compare.
module tb_cfg_chain_loader;

   localparam int NC = 4;
   localparam int WW = 8;
   localparam int CL = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cen = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          in_valid = 1'b0;
   logic [WW-1:0] in_data = '0;
   logic          in_ready, shift_en, set_out, busy, done;
   logic [NC-1:0] shift_out;

   logic          start1 = 1'b0;
   logic          in_valid1 = 1'b0;
   logic [WW-1:0] in_data1 = '0;
   logic          in_ready1, shift_en1, set_out1, busy1, done1;
   logic [NC-1:0] shift_out1;

   int errors = 0;
   int checks = 0;

   logic [3:0] exp_q[$];
   int         exp_set_q[$];
   logic [3:0] exp1_q[$];
   int         exp_set1_q[$];

   int tot_sh = 0, tot_set = 0, tot_hs = 0, sh_cnt = 0;
   int tot_sh1 = 0, tot_set1 = 0, sh_cnt1 = 0;
   int s_sh, s_set, s_hs;
   bit prev_sh = 1'b0;

   cfg_chain_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL), .WORD_W(WW)) dut (
      .clk(clk), .rst(rst), .cen(cen), .start(start), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .shift_out(shift_out), .shift_en(shift_en), .set_out(set_out),
      .busy(busy), .done(done)
   );

   cfg_chain_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(1), .WORD_W(WW)) dut1 (
      .clk(clk), .rst(rst), .cen(cen), .start(start1), .abort(abort),
      .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .shift_out(shift_out1), .shift_en(shift_en1), .set_out(set_out1),
      .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic fail_evt(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event with no expectation queued", name);
   endtask

   // monitor for the CHAIN_LEN=5 loader
   initial forever begin
      @(negedge clk);
      if (shift_en) begin
         tot_sh++;
         sh_cnt++;
         if (exp_q.size() == 0) fail_evt("unexpected_shift");
         else chk("shift_out", 32'(shift_out), 32'(exp_q.pop_front()));
      end
      if (set_out) begin
         tot_set++;
         if (exp_set_q.size() == 0) fail_evt("unexpected_set");
         else begin
            chk("set_after_shifts", 32'(sh_cnt), 32'(exp_set_q.pop_front()));
            chk("set_follows_last_shift", 32'(prev_sh), 32'd1);
         end
      end
      if (in_valid && in_ready) tot_hs++;
      if (cen) prev_sh = shift_en;
      if (!busy) sh_cnt = 0;
   end

   // monitor for the CHAIN_LEN=1 loader
   initial forever begin
      @(negedge clk);
      if (shift_en1) begin
         tot_sh1++;
         sh_cnt1++;
         if (exp1_q.size() == 0) fail_evt("unexpected_shift1");
         else chk("shift_out1", 32'(shift_out1), 32'(exp1_q.pop_front()));
      end
      if (set_out1) begin
         tot_set1++;
         if (exp_set1_q.size() == 0) fail_evt("unexpected_set1");
         else chk("set_after_shifts1", 32'(sh_cnt1), 32'(exp_set1_q.pop_front()));
      end
      if (!busy1) sh_cnt1 = 0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic snap();
      s_sh  = tot_sh;
      s_set = tot_set;
      s_hs  = tot_hs;
   endtask

   task automatic post(input string tag, input int nsh, input int nset, input int nhs);
      chk({tag, "_shift_en_cycles"}, 32'(tot_sh - s_sh), 32'(nsh));
      chk({tag, "_set_pulses"}, 32'(tot_set - s_set), 32'(nset));
      chk({tag, "_handshakes"}, 32'(tot_hs - s_hs), 32'(nhs));
      chk({tag, "_queues_drained"}, 32'(exp_q.size() + exp_set_q.size()), 32'd0);
   endtask

   // Drives one load cycle by cycle; masks are indexed by cycle number after start.
   task automatic run_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                           input logic [WW-1:0] w2, input logic [19:0] enib, input int nexp,
                           input logic [31:0] cen_off, input logic [31:0] vld_off,
                           input logic [31:0] start_on, input int abort_at);
      logic [WW-1:0] w[3];
      int  k;
      int  c;
      bit  hs;
      bit  fin;
      w[0] = w0; w[1] = w1; w[2] = w2;
      k = 0; c = 0; fin = 1'b0;
      for (int b = 0; b < nexp; b++) exp_q.push_back(enib[4*b +: 4]);
      if (abort_at < 0) exp_set_q.push_back(CL);
      while (!fin) begin
         cen      = !cen_off[c];
         in_valid = !vld_off[c];
         start    = start_on[c];
         abort    = (c == abort_at);
         if (k < 3) in_data = w[k];
         else       in_data = '0;
         @(negedge clk);
         hs = in_valid && in_ready;
         if (cen_off[c]) begin
            chk("frozen_outputs", 32'({shift_en, set_out, in_ready}), 32'd0);
            chk("frozen_busy", 32'(busy), 32'd1);
         end
         if (vld_off[c] && !cen_off[c])
            chk("gap_ready_no_shift", 32'({in_ready, shift_en}), 32'b10);
         tick();
         if (hs) k++;
         c++;
         if ((abort_at >= 0) ? (c > abort_at) : (done == 1'b1)) fin = 1'b1;
         else if (c >= 32) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: no done after %0d cycles", c);
            fin = 1'b1;
         end
      end
      cen = 1'b1; in_valid = 1'b0; start = 1'b0; abort = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({in_ready, shift_out, shift_en, set_out, busy, done}), 32'd0);
      rst = 1'b1;
      tick();

      // plain load with in_valid held high
      snap();
      do_start();
      chk("busy_after_start", 32'({busy, done}), 32'b10);
      run_load(8'h21, 8'h43, 8'hF5, 20'h54321, 5, 32'd0, 32'd0, 32'd0, -1);
      chk("done_after_load", 32'({done, busy}), 32'b10);
      post("plain", 5, 1, 3);

      // 3-cycle valid gap in the second FILL, stray starts mid-load
      snap();
      do_start();
      run_load(8'h98, 8'hBA, 8'h0C, 20'hCBA98, 5, 32'd0, 32'b111 << 3,
               (32'd1 << 1) | (32'd1 << 4), -1);
      chk("done_after_gap", 32'({done, busy}), 32'b10);
      post("gap", 5, 1, 3);

      // restart from DONE, with cen low mid-SHIFT and during SET
      snap();
      chk("done_before_restart", 32'(done), 32'd1);
      do_start();
      chk("done_drops_on_start", 32'({busy, done}), 32'b10);
      run_load(8'h21, 8'h43, 8'hF5, 20'h54321, 5, (32'b11 << 2) | (32'b11 << 10),
               32'd0, 32'd0, -1);
      chk("done_after_cen_pause", 32'({done, busy}), 32'b10);
      post("cen", 5, 1, 3);

      // abort in the second SHIFT cycle
      snap();
      do_start();
      run_load(8'h21, 8'h43, 8'hF5, 20'h54321, 2, 32'd0, 32'd0, 32'd0, 2);
      chk("abort_idle", 32'({busy, done, set_out, in_ready}), 32'd0);
      repeat (3) tick();
      chk("abort_stays_idle", 32'({busy, done}), 32'd0);
      post("abort", 2, 0, 1);

      snap();
      do_start();
      run_load(8'h21, 8'h43, 8'hF5, 20'h54321, 5, 32'd0, 32'd0, 32'd0, -1);
      chk("done_after_abort_reload", 32'({done, busy}), 32'b10);
      post("reload", 5, 1, 3);

      // asynchronous reset mid-SHIFT
      do_start();
      in_valid = 1'b1;
      in_data  = 8'h21;
      tick();
      in_valid = 1'b0;
      chk("pre_reset_shift_en", 32'(shift_en), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("async_reset_outputs", 32'({in_ready, shift_out, shift_en, set_out, busy, done}), 32'd0);
      chk("async_reset_outputs1",
          32'({in_ready1, shift_out1, shift_en1, set_out1, busy1, done1}), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      chk("post_reset_idle", 32'({in_ready, busy, done}), 32'd0);

      // CHAIN_LEN=1: one shift of the low nibble, then set
      exp1_q.push_back(4'hA);
      exp_set1_q.push_back(1);
      start1 = 1'b1;
      tick();
      start1    = 1'b0;
      in_valid1 = 1'b1;
      in_data1  = 8'h3A;
      for (int i = 0; i < 10 && !done1; i++) tick();
      in_valid1 = 1'b0;
      chk("cl1_done", 32'({done1, busy1}), 32'b10);
      chk("cl1_shift_count", 32'(tot_sh1), 32'd1);
      chk("cl1_set_count", 32'(tot_set1), 32'd1);
      chk("cl1_queues_drained", 32'(exp1_q.size() + exp_set1_q.size()), 32'd0);

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
